// File: rtl/display_7seg_ndigit_if.sv
// Bundle of the multiplexed 7-segment display controller's data and status signals.
// The master side supplies display contents; the slave side is the controller.
interface display_7seg_ndigit_if #(
   parameter int NDIGITS = 8
);
   logic [4*NDIGITS-1:0] nums;
   logic [NDIGITS-1:0]   nums_enable;
   logic [NDIGITS-1:0]   dots_enable;
   logic [NDIGITS-1:0]   blink_enable;
   logic [3:0]           brightness;
   logic                 load;
   logic                 pending;
   logic                 frame_done;
   logic [6:0]           hex;
   logic                 hex_dot;
   logic [NDIGITS-1:0]   hex_sel;

   modport master (
      output nums, nums_enable, dots_enable, blink_enable, brightness, load,
      input  pending, frame_done, hex, hex_dot, hex_sel
   );

   modport slave (
      input  nums, nums_enable, dots_enable, blink_enable, brightness, load,
      output pending, frame_done, hex, hex_dot, hex_sel
   );
endinterface

// File: rtl/display_7seg_ndigit.sv
// Time-multiplexed N-digit 7-segment driver with PWM brightness, per-digit blink,
// and updates double-buffered so new contents only take effect on a frame boundary.
module display_7seg_ndigit #(
   parameter int NDIGITS      = 8,
   parameter int DIV_BITS     = 15,
   parameter int BLINK_FRAMES = 6
) (
   input logic clk,
   input logic rst,
   display_7seg_ndigit_if.slave bus
);
   localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

   logic [DIV_BITS-1:0]     z;
   logic [IDXW-1:0]         idx;
   logic [BLINK_FRAMES-1:0] frames;
   logic                    blink_phase;
   logic                    frame_done;
   logic                    pending;
   logic                    slot_end;
   logic                    boundary;

   logic [4*NDIGITS-1:0] buf_nums, act_nums;
   logic [NDIGITS-1:0]   buf_en, act_en;
   logic [NDIGITS-1:0]   buf_dots, act_dots;
   logic [NDIGITS-1:0]   buf_blink, act_blink;
   logic [3:0]           buf_bri, act_bri;

   logic [3:0]         nibble;
   logic               lit;
   logic [6:0]         hex;
   logic               hex_dot;
   logic [NDIGITS-1:0] hex_sel;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h46;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   assign slot_end = &z;
   assign boundary = slot_end && (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         z           <= '0;
         idx         <= '0;
         frames      <= '0;
         blink_phase <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         z          <= z + 1'b1;
         frame_done <= boundary;
         if (slot_end)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         if (boundary) begin
            frames <= frames + 1'b1;
            if (&frames)
               blink_phase <= ~blink_phase;
         end
      end
   end

   // A load on the boundary cycle goes straight to the active set, bypassing the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= 1'b0;
         buf_nums  <= '0;
         buf_en    <= '0;
         buf_dots  <= '0;
         buf_blink <= '0;
         buf_bri   <= '0;
         act_nums  <= '0;
         act_en    <= '0;
         act_dots  <= '0;
         act_blink <= '0;
         act_bri   <= '0;
      end else begin
         if (bus.load) begin
            buf_nums  <= bus.nums;
            buf_en    <= bus.nums_enable;
            buf_dots  <= bus.dots_enable;
            buf_blink <= bus.blink_enable;
            buf_bri   <= bus.brightness;
         end
         if (boundary && (pending || bus.load)) begin
            act_nums  <= bus.load ? bus.nums         : buf_nums;
            act_en    <= bus.load ? bus.nums_enable  : buf_en;
            act_dots  <= bus.load ? bus.dots_enable  : buf_dots;
            act_blink <= bus.load ? bus.blink_enable : buf_blink;
            act_bri   <= bus.load ? bus.brightness   : buf_bri;
         end
         if (boundary)
            pending <= 1'b0;
         else if (bus.load)
            pending <= 1'b1;
      end
   end

   always_comb begin
      nibble = act_nums[4*idx +: 4];
      lit    = act_en[idx] && (z[DIV_BITS-1 -: 4] <= act_bri) &&
               !(act_blink[idx] && blink_phase);
   end

   always_ff @(posedge clk) begin
      if (rst || !lit) begin
         hex_sel <= '1;
         hex     <= 7'h7F;
         hex_dot <= 1'b1;
      end else begin
         hex_sel <= ~(NDIGITS'(1) << idx);
         hex     <= seg7(nibble);
         hex_dot <= ~act_dots[idx];
      end
   end

   assign bus.pending    = pending;
   assign bus.frame_done = frame_done;
   assign bus.hex        = hex;
   assign bus.hex_dot    = hex_dot;
   assign bus.hex_sel    = hex_sel;
endmodule

// File: tb/tb_display_7seg_ndigit.sv
// Directed bench for display_7seg_ndigit with 3 digits, 16-cycle slots and a
// blink phase that flips every 2 frames; each frame is checked cycle by cycle.
module tb_display_7seg_ndigit;
   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   display_7seg_ndigit_if #(.NDIGITS(3)) bus ();

   display_7seg_ndigit #(
      .NDIGITS(3),
      .DIV_BITS(4),
      .BLINK_FRAMES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [6:0] segOf(input logic [3:0] v);
      case (v)
         4'h0:    segOf = 7'b1000000;
         4'h1:    segOf = 7'b1111001;
         4'h2:    segOf = 7'b0100100;
         4'h3:    segOf = 7'b0110000;
         4'h4:    segOf = 7'b0011001;
         4'h5:    segOf = 7'b0010010;
         4'h6:    segOf = 7'b0000010;
         4'h7:    segOf = 7'b1111000;
         4'h8:    segOf = 7'b0000000;
         4'h9:    segOf = 7'b0010000;
         4'hA:    segOf = 7'b0001000;
         4'hB:    segOf = 7'b0000011;
         4'hC:    segOf = 7'b1000110;
         4'hD:    segOf = 7'b0100001;
         4'hE:    segOf = 7'b0000110;
         default: segOf = 7'b0001110;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One full frame starting right after a boundary edge; optionally pulses load at offset loadOff.
   task automatic checkFrame(input string name, input int loadOff,
                             input logic [11:0] lNums, input logic [2:0] lEn,
                             input logic [2:0] lDots, input logic [2:0] lBlink,
                             input logic [3:0] lBri,
                             input logic [11:0] eNums, input logic [2:0] eEn,
                             input logic [2:0] eDots, input logic [2:0] eBlink,
                             input logic [3:0] eBri);
      int         m;
      int         s;
      int         k;
      int         zz;
      logic       bp;
      logic       lit;
      logic       expPend;
      logic [2:0] one;
      logic [2:0] eSel;
      logic [6:0] eHex;
      logic       eDot;
      one = 3'b001;
      m   = cyc / 48;
      bp  = ((m >> 1) & 1) == 1;
      for (int i = 0; i < 48; i++) begin
         if (i == loadOff) begin
            bus.load         = 1'b1;
            bus.nums         = lNums;
            bus.nums_enable  = lEn;
            bus.dots_enable  = lDots;
            bus.blink_enable = lBlink;
            bus.brightness   = lBri;
         end
         tick();
         bus.load = 1'b0;
         s   = (cyc - 1) % 48;
         k   = s / 16;
         zz  = s % 16;
         lit = eEn[k] && (zz <= int'(eBri)) && !(eBlink[k] && bp);
         eSel = lit ? ~(one << k) : 3'b111;
         eHex = lit ? segOf(eNums[k*4 +: 4]) : 7'h7F;
         eDot = lit ? ~eDots[k] : 1'b1;
         expPend = (loadOff >= 0) && (loadOff < 47) && (i >= loadOff) && (i < 47);
         chk({name, ".hex_sel"}, 32'(bus.hex_sel), 32'(eSel));
         chk({name, ".hex"}, 32'(bus.hex), 32'(eHex));
         chk({name, ".hex_dot"}, 32'(bus.hex_dot), 32'(eDot));
         chk({name, ".pending"}, 32'(bus.pending), 32'(expPend));
         chk({name, ".frame_done"}, 32'(bus.frame_done), 32'(i == 47));
      end
   endtask

   initial begin
      cyc                = 0;
      checks             = 0;
      errors             = 0;
      rst                = 1'b1;
      bus.load           = 1'b0;
      bus.nums           = '0;
      bus.nums_enable    = '0;
      bus.dots_enable    = '0;
      bus.blink_enable   = '0;
      bus.brightness     = '0;
      repeat (3) tick();
      cyc = 0;
      rst = 1'b0;
      chk("rst.hex_sel", 32'(bus.hex_sel), 32'(3'b111));
      chk("rst.hex", 32'(bus.hex), 32'(7'h7F));
      chk("rst.hex_dot", 32'(bus.hex_dot), 32'(1'b1));
      chk("rst.pending", 32'(bus.pending), 32'(1'b0));
      chk("rst.frame_done", 32'(bus.frame_done), 32'(1'b0));

      // Frame 0: load 5A3 at full brightness; display stays blank until the first boundary.
      checkFrame("f0", 0, 12'h5A3, 3'b111, 3'b000, 3'b000, 4'd15,
                 12'h000, 3'b000, 3'b000, 3'b000, 4'd0);
      checkFrame("f1", -1, 12'h000, 3'b000, 3'b000, 3'b000, 4'd0,
                 12'h5A3, 3'b111, 3'b000, 3'b000, 4'd15);
      checkFrame("f2", 3, 12'h5A3, 3'b111, 3'b000, 3'b000, 4'd3,
                 12'h5A3, 3'b111, 3'b000, 3'b000, 4'd15);
      // Brightness 3, with a mid-frame load that must not tear the current frame.
      checkFrame("f3", 20, 12'hC71, 3'b111, 3'b100, 3'b000, 4'd15,
                 12'h5A3, 3'b111, 3'b000, 3'b000, 4'd3);
      // Load lands exactly on the boundary cycle.
      checkFrame("f4", 47, 12'h9E0, 3'b111, 3'b000, 3'b010, 4'd15,
                 12'hC71, 3'b111, 3'b100, 3'b000, 4'd15);
      checkFrame("f5", -1, 12'h000, 3'b000, 3'b000, 3'b000, 4'd0,
                 12'h9E0, 3'b111, 3'b000, 3'b010, 4'd15);
      checkFrame("f6", -1, 12'h000, 3'b000, 3'b000, 3'b000, 4'd0,
                 12'h9E0, 3'b111, 3'b000, 3'b010, 4'd15);
      checkFrame("f7", -1, 12'h000, 3'b000, 3'b000, 3'b000, 4'd0,
                 12'h9E0, 3'b111, 3'b000, 3'b010, 4'd15);
      checkFrame("f8", -1, 12'h000, 3'b000, 3'b000, 3'b000, 4'd0,
                 12'h9E0, 3'b111, 3'b000, 3'b010, 4'd15);

      // Mid-slot reset with a pending update and load held during reset.
      repeat (5) tick();
      bus.load = 1'b1;
      bus.nums = 12'h123;
      tick();
      bus.load = 1'b0;
      chk("mid.pending", 32'(bus.pending), 32'(1'b1));
      repeat (3) tick();
      rst      = 1'b1;
      bus.load = 1'b1;
      tick();
      chk("rst2.hex_sel", 32'(bus.hex_sel), 32'(3'b111));
      chk("rst2.hex", 32'(bus.hex), 32'(7'h7F));
      chk("rst2.hex_dot", 32'(bus.hex_dot), 32'(1'b1));
      chk("rst2.pending", 32'(bus.pending), 32'(1'b0));
      chk("rst2.frame_done", 32'(bus.frame_done), 32'(1'b0));
      chk("rst2.z", 32'(dut.z), 32'(0));
      chk("rst2.idx", 32'(dut.idx), 32'(0));
      rst      = 1'b0;
      bus.load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post.hex_sel", 32'(bus.hex_sel), 32'(3'b111));
         chk("post.pending", 32'(bus.pending), 32'(1'b0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/display_7seg_ndigit.md
DISPLAY_7SEG_NDIGIT -- requirements
Module: display_7seg_ndigit

Interface
REQ-001 SHALL have parameter NDIGITS, default 8: digit count, legal range 1..16, power of two not required.
REQ-002 SHALL have parameter DIV_BITS, default 15: each digit slot lasts 2^DIV_BITS clk cycles; minimum 4.
REQ-003 SHALL have parameter BLINK_FRAMES, default 6: blink phase toggles every 2^BLINK_FRAMES complete frames.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port nums, input, 4*NDIGITS: nibble i (bits 4i+3..4i) is the hex value for digit i.
REQ-007 SHALL have port nums_enable, input, NDIGITS: bit i=1 enables digit i.
REQ-008 SHALL have port dots_enable, input, NDIGITS: bit i=1 lights the dot of digit i.
REQ-009 SHALL have port blink_enable, input, NDIGITS: bit i=1 makes digit i blink.
REQ-010 SHALL have port brightness, input, 4: duty level 0..15.
REQ-011 SHALL have port load, input, 1: request to capture nums/nums_enable/dots_enable/blink_enable/brightness.
REQ-012 SHALL have port pending, output, 1: a captured update awaits the frame boundary.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse after each frame boundary.
REQ-014 SHALL have port hex, output, 7: segments a..g on bits 0..6, active low.
REQ-015 SHALL have port hex_dot, output, 1: dot segment, active low.
REQ-016 SHALL have port hex_sel, output, NDIGITS: digit anodes, active low, one-hot-low or all ones.

Function
REQ-017 SHALL keep a DIV_BITS-bit slot counter Z, incrementing every cycle and wrapping from all-ones to 0.
REQ-018 SHALL advance digit index idx by one when Z is all ones, wrapping from NDIGITS-1 to 0.
REQ-019 SHALL define the frame boundary as the cycle with Z all ones and idx==NDIGITS-1.
REQ-020 SHALL copy the inputs into a pending buffer and set pending on every cycle where load=1; a later load overwrites the buffer.
REQ-021 SHALL transfer to active registers at a frame boundary when pending=1 or load=1, taking values from the inputs if load=1, otherwise from the pending buffer, and clear pending that cycle.
REQ-022 SHALL drive pending as a register: 1 from the cycle after a non-boundary load until the cycle after the transfer; a load on the boundary cycle leaves pending at 0.
REQ-023 SHALL pulse frame_done high for exactly one cycle, the cycle after each frame boundary.
REQ-024 SHALL keep a BLINK_FRAMES-bit frame counter; on its wrap at a frame boundary, toggle blink_phase.
REQ-025 SHALL light digit idx only when all of these hold: active enable bit=1; Z[DIV_BITS-1:DIV_BITS-4] <= active brightness; not (active blink bit=1 and blink_phase=1).
REQ-026 SHALL register all display outputs, one cycle after the Z/idx state that produced them.
REQ-027 When digit idx is lit, SHALL drive hex_sel bit idx=0 and all others=1, hex=the active-low encoding of nibble idx (bin_to_7seg 0-F table), and hex_dot=~active dot bit.
REQ-028 When digit idx is not lit, SHALL drive hex_sel all ones, hex=7'b1111111 and hex_dot=1.

Reset
REQ-029 SHALL, on rst=1, clear Z, idx, frame counter, blink_phase, pending, frame_done, the pending buffer and all active registers (brightness=0, enables=0).
REQ-030 SHALL drive hex_sel all ones, hex=7'b1111111 and hex_dot=1 in the cycle after rst.
REQ-031 SHALL give rst priority over load; a load during rst is discarded.

Verification (NDIGITS=3, DIV_BITS=4, BLINK_FRAMES=1)
REQ-032 SHALL verify: reset, then load nums=12'h5A3, enables=3'b111, brightness=15 -> pending=1 until the first boundary; then hex_sel cycles 110,101,011 for 16 cycles each, with hex showing 3, A, 5.
REQ-033 SHALL verify: brightness=3 -> within each 16-cycle slot hex_sel is active for 4 cycles and all ones for 12 cycles.
REQ-034 SHALL verify: load pulsed mid-frame with new nums -> displayed digits stay unchanged until the boundary and change starting in the next frame (no tearing); frame_done pulses once per 48 cycles.
REQ-035 SHALL verify: load asserted exactly on the boundary cycle -> new values are active next frame and pending stays 0.
REQ-036 SHALL verify: blink_enable=3'b010 -> digit 1 is blanked during 2 of every 4 frames while digits 0 and 2 stay lit.
REQ-037 SHALL verify: rst asserted mid-slot -> next cycle has outputs blank, pending=0, idx=0, Z=0.
